// File: rtl/axil_master_bridge.sv
`default_nettype none
//============================================================================
// Module  : axil_master_bridge
// Desc    : Single-outstanding AXI4-Lite initiator. A valid/ready command is
//           turned into one AXI4-Lite read or write. The result is held on a
//           valid/ready response port until it is consumed.
// Options : AXIL_MASTER_TIMEOUT_EN - response timeout with SLVERR and a
//           DRAIN state that absorbs late beats.
// Rev     : 1.0 - initial release
//============================================================================
module axil_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    m_axi_aclk,
   input  logic                    m_axi_areset,
   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   // AXI4-Lite write address
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   // AXI4-Lite write data
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   // AXI4-Lite write response
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   // AXI4-Lite read address
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   // AXI4-Lite read data
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   // Reject unsupported configurations at elaboration.
   if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64)) || (TIMEOUT_CYCLES < 2)) begin : g_bad_param
      $error("axil_master_bridge: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_RSP   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                  r_state, w_next;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_write;
   logic                    r_awvalid, r_wvalid, r_arvalid;
   logic                    r_aw_done, r_w_done, r_b_done, r_ar_done, r_r_done;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [1:0]              r_resp;
   logic                    w_bready, w_rready;
   logic                    w_accept;
   logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic                    w_wr_done, w_rd_done, w_done;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
   logic [c_cnt_w-1:0]      r_cnt;
   logic                    r_timeout;
   logic                    w_tmo;
`endif

   assign w_accept  = cmd_valid & (r_state == S_IDLE);
   assign w_aw_hs   = r_awvalid & m_axi_awready;
   assign w_w_hs    = r_wvalid  & m_axi_wready;
   assign w_ar_hs   = r_arvalid & m_axi_arready;
   assign w_b_hs    = m_axi_bvalid & w_bready;
   assign w_r_hs    = m_axi_rvalid & w_rready;
   // Completion includes handshakes happening in the current cycle.
   assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs) & (r_b_done | w_b_hs);
   assign w_rd_done = (r_ar_done | w_ar_hs) & (r_r_done | w_r_hs);
   assign w_done    = r_write ? w_wr_done : w_rd_done;

`ifdef AXIL_MASTER_TIMEOUT_EN
   assign w_tmo = ((r_state == S_WRITE) || (r_state == S_READ)) && !w_done &&
                  (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout = r_timeout;
`else
   assign rsp_timeout = 1'b0;
`endif

   // Response readies: open only while the matching beat is expected.
   always_comb begin
      w_bready = (r_state == S_WRITE);
      w_rready = (r_state == S_READ);
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (r_timeout && ((r_state == S_RSP) || (r_state == S_DRAIN))) begin
         w_bready = r_write & ~r_b_done;
         w_rready = ~r_write & ~r_r_done;
      end
`endif
   end

   assign cmd_ready     = (r_state == S_IDLE);
   assign rsp_valid     = (r_state == S_RSP);
   assign rsp_rdata     = r_rdata;
   assign rsp_resp      = r_resp;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_araddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_bready  = w_bready;
   assign m_axi_rready  = w_rready;

   // State register.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) r_state <= S_IDLE;
      else              r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_next = cmd_write ? S_WRITE : S_READ;
         S_WRITE: begin
            if (w_wr_done) w_next = S_RSP;
`ifdef AXIL_MASTER_TIMEOUT_EN
            else if (w_tmo) w_next = S_RSP;
`endif
         end
         S_READ: begin
            if (w_rd_done) w_next = S_RSP;
`ifdef AXIL_MASTER_TIMEOUT_EN
            else if (w_tmo) w_next = S_RSP;
`endif
         end
         S_RSP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
               if (r_timeout && !w_done) w_next = S_DRAIN;
`endif
            end
         end
`ifdef AXIL_MASTER_TIMEOUT_EN
         S_DRAIN: if (w_done) w_next = S_IDLE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // Command latch, AXI valids, step tracking and response capture.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_write   <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_arvalid <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_b_done  <= 1'b0;
         r_ar_done <= 1'b0;
         r_r_done  <= 1'b0;
         r_rdata   <= '0;
         r_resp    <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
         r_cnt     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         if (w_aw_hs) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
         if (w_w_hs)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
         if (w_ar_hs) begin r_arvalid <= 1'b0; r_ar_done <= 1'b1; end
         if (w_b_hs)  r_b_done <= 1'b1;
         if (w_r_hs)  r_r_done <= 1'b1;
         // Only beats belonging to the live transaction update the result.
         if ((r_state == S_WRITE) && w_b_hs && !r_b_done) r_resp <= m_axi_bresp;
         if ((r_state == S_READ) && w_r_hs) begin
            r_rdata <= m_axi_rdata;
            r_resp  <= m_axi_rresp;
         end
`ifdef AXIL_MASTER_TIMEOUT_EN
         if ((r_state == S_WRITE) || (r_state == S_READ)) r_cnt <= r_cnt + 1'b1;
         if (w_tmo) begin
            r_timeout <= 1'b1;
            r_resp    <= 2'b10;
            r_rdata   <= '0;
         end
`endif
         if (w_accept) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_write   <= cmd_write;
            r_awvalid <= cmd_write;
            r_wvalid  <= cmd_write;
            r_arvalid <= ~cmd_write;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_ar_done <= 1'b0;
            r_r_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/axil_master_bridge.md
# axil_master_bridge

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command port into AXI4-Lite read or write transactions and returns the response on a valid/ready response port. It sits between local control logic (sequencers, test drivers, soft controllers) and any AXI4-Lite slave peripheral in the system, such as the Basys 3 GPIO block. It issues one transaction at a time, tracks the write-address and write-data handshakes independently, and holds the result until it is consumed.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- TIMEOUT_CYCLES, 1024, response timeout in clocks; used only with the timeout feature.
- m_axi_aclk  in  1  clock; all logic is on the rising edge.
- m_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code (BRESP or RRESP).
- rsp_timeout  out  1  response was produced by the timeout.
- m_axi_aw{addr,prot,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,prot,valid,ready}, m_axi_r{data,resp,valid,ready}: standard AXI4-Lite master directions and widths.
- awprot and arprot are tied to 3'b000.

## Operation
- **States:** IDLE, WRITE, READ, RSP, DRAIN. DRAIN exists only with the timeout feature.
- **IDLE:**
  - cmd_ready = 1.
  - When cmd_valid & cmd_ready, the block latches addr, wdata, wstrb and cmd_write.
  - It then goes to WRITE or READ.
- **WRITE:**
  - awvalid and wvalid both rise on entry.
  - Each drops on the cycle after its own handshake (valid & ready), in any order or simultaneously.
  - bready = 1 for the whole state.
  - B may be accepted in the same cycle as, or before completion of, either address/data handshake.
  - bresp is captured on bvalid & bready.
  - Exit to RSP once all three of AW, W and B are done.
- **READ:**
  - arvalid rises on entry and drops after its handshake.
  - rready = 1 for the whole state.
  - rdata and rresp are captured on rvalid & rready.
  - Exit to RSP once both AR and R are done.
- **RSP:**
  - rsp_valid = 1, with the captured rdata/resp stable.
  - rsp_ready = 1 returns the block to IDLE.
  - cmd_ready = 0 throughout.
- AXI valid signals never drop before their handshake, and payloads stay stable while valid is high.
- A B or R beat arriving outside the matching state is not accepted, because the corresponding ready is 0.
- **Reset:**
  - Returns the block to IDLE immediately.
  - All valid and ready outputs go to 0, except cmd_ready, which goes to 1 after reset.
  - Latched data, rsp_rdata and rsp_resp reset to 0.
  - An in-flight transaction is abandoned; the slave is expected to be reset by the same reset.

## Timing
- Command accept in cycle N → awvalid/wvalid (or arvalid) high in N+1 (registered).
- Against a zero-wait slave (ready and response in the same cycle as valid): rsp_valid is high in N+2.
- Minimum issue interval is 3 cycles per transaction: accept, transfer, response.
- The next cmd accept is at the earliest in the cycle after rsp_valid & rsp_ready.
- All outputs are registered, with no combinational path from AXI inputs to AXI outputs.
- The only input-to-output paths are the readies/valids gated by state: cmd_ready depends only on state.

## Configuration
- **AXIL_MASTER_TIMEOUT_EN defined:**
  - A cycle counter clears on entry to WRITE or READ and increments each cycle while in that state.
  - When it reaches TIMEOUT_CYCLES, the block enters RSP with rsp_resp = 2'b10 (SLVERR), rsp_timeout = 1 and rsp_rdata = 0.
  - Outstanding AXI valids stay asserted until their handshake; bready/rready stay 1.
  - After rsp_valid & rsp_ready, the block enters DRAIN rather than IDLE if any AW, W, AR, B or R step is still pending.
  - DRAIN holds cmd_ready = 0 and completes and discards the late beats, then moves to IDLE.
- **Not defined:**
  - No counter and no DRAIN state; the block waits indefinitely.
  - rsp_timeout is tied to 0.

## Test plan
- **Write, zero-wait slave:** write addr 0x04, data 0x0000_A5A5, strb 0xF → AW and W handshakes in N+1, rsp_valid in N+2 with rsp_resp 0, rsp_rdata 0.
- **Read:** read addr 0x08 with the slave returning 0x0000_1234 after 3 wait cycles → rsp_rdata 0x0000_1234, rsp_resp 0, and arvalid held high until arready.
- **Split write handshakes:**
  - Stimulus: wready high at N+1, awready delayed to N+4, bvalid at N+4.
  - Required: wvalid low from N+2, awvalid high until N+4, rsp_valid at N+5.
- **Error and backpressure:** write to unmapped 0x3C with bresp 2'b10, and rsp_ready low for 5 cycles → rsp_resp 2'b10 held stable, cmd_ready 0 until the handshake.
- **Timeout (macro on, TIMEOUT_CYCLES = 16):** slave never asserts arready → rsp_valid with rsp_timeout 1 and resp 2'b10 at 16 cycles after entry to READ; a late arready/rvalid is drained, then cmd_ready returns to 1.
- **Reset mid-write:** assert m_axi_areset while awvalid is high → awvalid, wvalid, bready and rsp_valid go to 0 asynchronously, and cmd_ready is 1 after reset release.
